lsu_ctrl: RTL and testbench

Load/store access controller between the core's LSU request port and the two data targets, data memory and peripheral bus. It accepts one request at a time, decodes the 12-bit address into a target region, and drives `addr_sel_o` for the existing address demux. It sequences the wait-state access, aligns store data and byte masks, and extracts and extends load data. It returns a single-cycle response and holds `busy_o` so the pipeline stalls for the whole access.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_align.sv | 67 ++++++
 rtl/lsu_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM    = 2'd1,
    ST_PERIPH = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  localparam logic [1:0] ADDR_SEL_MEM    = 2'b00;
  localparam logic [1:0] ADDR_SEL_PERIPH = 2'b10;
  localparam logic [1:0] ADDR_SEL_NONE   = 2'b11;

  localparam int PERIPH_BIT = 11;

  // Request captured at handshake and held for the whole access.
  typedef struct packed {
    logic [11:0] addr;
    logic        we;
    lsu_size_e   size;
    logic        uns;
    logic [31:0] wdata;
  } lsu_req_t;

  // Misaligned half/word or reserved size: such requests never reach a target.
  function automatic logic lsu_misaligned(input logic [1:0] a, input lsu_size_e s);
    logic bad;
    bad = 1'b0;
    case (s)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane replication / byte-mask generation and load extract / extend.
// Latency: combinational.
// Backpressure: none; follows the registered request of lsu_ctrl.
// Ports: i_size/i_unsigned/i_addr (registered request fields), i_wdata
//        (right-aligned store data), i_rdata (raw target read data),
//        o_wdata/o_bmask (lane-aligned store), o_rdata (extended load).
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_bmask,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: replicate so every enabled lane sees the right bytes.
  always_comb begin
    o_wdata = i_wdata;
    o_bmask = 4'b0000;
    case (i_size)
      SZ_BYTE: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_bmask = 4'b0001 << i_addr;
      end
      SZ_HALF: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_bmask = 4'b0011 << i_addr;
      end
      SZ_WORD: begin
        o_wdata = i_wdata;
        o_bmask = 4'b1111;
      end
      default: begin
        o_wdata = i_wdata;
        o_bmask = 4'b0000;
      end
    endcase
  end

  // Load side: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    w_byte = 8'h00;
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_rdata = 32'h0;
    case (i_size)
      SZ_BYTE: o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      SZ_WORD: o_rdata = i_rdata;
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store access controller: one request at a time to data memory or peripheral bus.
// Latency: memory response in cycle MEM_LAT+1, peripheral one cycle after ack, error in cycle 1.
// Backpressure: req_ready_o low from cycle 1 until back in IDLE; response has no backpressure.
// Ports: req_* (LSU request), addr_sel_o/addr_o (address demux), mem_*/periph_*
//        (target strobes and read data), bmask_o/wdata_o (aligned store),
//        rsp_* (one-cycle response), busy_o (pipeline stall).
// Optional: LSU_CTRL_TIMEOUT_EN enables the peripheral ack timeout (TIMEOUT_CYC).
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_LAT     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [11:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic [1:0]  addr_sel_o,
  output logic [11:0] addr_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic        periph_en_o,
  output logic        periph_we_o,
  output logic [3:0]  bmask_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic [31:0] periph_rdata_i,
  input  logic        periph_ack_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  lsu_state_e  r_state;
  lsu_state_e  w_state_nxt;
  lsu_req_t    r_req;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [CW-1:0] r_cnt;

  logic        w_accept;
  logic        w_in_err;
  logic        w_capture;
  logic [31:0] w_ld_raw;
  logic [31:0] w_ld_ext;
  logic [31:0] w_st_data;
  logic [3:0]  w_st_bmask;

`ifdef LSU_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] r_tcnt;
  logic          w_tmo;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

  assign w_accept = req_valid_i && (r_state == ST_IDLE);
  assign w_in_err = lsu_misaligned(req_addr_i[1:0], lsu_size_e'(req_size_i));
  // Read data source follows the active target.
  assign w_ld_raw = (r_state == ST_PERIPH) ? periph_rdata_i : mem_rdata_i;

  lsu_align u_align (
    .i_size     (r_req.size),
    .i_unsigned (r_req.uns),
    .i_addr     (r_req.addr[1:0]),
    .i_wdata    (r_req.wdata),
    .i_rdata    (w_ld_raw),
    .o_wdata    (w_st_data),
    .o_bmask    (w_st_bmask),
    .o_rdata    (w_ld_ext)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    req_ready_o = 1'b0;
    addr_sel_o  = ADDR_SEL_NONE;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    periph_en_o = 1'b0;
    periph_we_o = 1'b0;
    bmask_o     = 4'b0000;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = 32'h0;
    rsp_err_o   = 1'b0;
`ifdef LSU_CTRL_TIMEOUT_EN
    w_tmo       = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (w_in_err)                     w_state_nxt = ST_RESP;
          else if (req_addr_i[PERIPH_BIT])  w_state_nxt = ST_PERIPH;
          else                              w_state_nxt = ST_MEM;
        end
      end
      ST_MEM: begin
        addr_sel_o = ADDR_SEL_MEM;
        mem_en_o   = 1'b1;
        mem_we_o   = r_req.we;
        bmask_o    = w_st_bmask;
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_PERIPH: begin
        addr_sel_o  = ADDR_SEL_PERIPH;
        periph_en_o = 1'b1;
        periph_we_o = r_req.we;
        bmask_o     = w_st_bmask;
        if (periph_ack_i) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
`ifdef LSU_CTRL_TIMEOUT_EN
        // An ack on the final allowed cycle still completes normally.
        else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = r_rdata;
        rsp_err_o   = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req   <= '0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
      r_cnt   <= '0;
`ifdef LSU_CTRL_TIMEOUT_EN
      r_tcnt  <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_req.addr  <= req_addr_i;
        r_req.we    <= req_we_i;
        r_req.size  <= lsu_size_e'(req_size_i);
        r_req.uns   <= req_unsigned_i;
        r_req.wdata <= req_wdata_i;
        r_err       <= w_in_err;
        r_rdata     <= 32'h0;
        r_cnt       <= CW'(MEM_LAT - 1);
`ifdef LSU_CTRL_TIMEOUT_EN
        r_tcnt      <= '0;
`endif
      end
      if (r_state == ST_MEM && r_cnt != '0)
        r_cnt <= r_cnt - CW'(1);
      // Stores always respond with zero data.
      if (w_capture)
        r_rdata <= r_req.we ? 32'h0 : w_ld_ext;
`ifdef LSU_CTRL_TIMEOUT_EN
      if (r_state == ST_PERIPH)
        r_tcnt <= r_tcnt + TW'(1);
      if (w_tmo) begin
        r_err   <= 1'b1;
        r_rdata <= 32'h0;
      end
`endif
    end
  end

  assign addr_o  = r_req.addr;
  assign wdata_o = w_st_data;
  assign busy_o  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  localparam int MEM_LAT     = 2;
  localparam int TIMEOUT_CYC = 16;

  logic        clk_i;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [11:0] req_addr_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  addr_sel_o;
  logic [11:0] addr_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic        periph_en_o;
  logic        periph_we_o;
  logic [3:0]  bmask_o;
  logic [31:0] wdata_o;
  logic [31:0] mem_rdata_i;
  logic [31:0] periph_rdata_i;
  logic        periph_ack_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_ctrl #(.MEM_LAT(MEM_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_wdata_i    (req_wdata_i),
    .addr_sel_o     (addr_sel_o),
    .addr_o         (addr_o),
    .mem_en_o       (mem_en_o),
    .mem_we_o       (mem_we_o),
    .periph_en_o    (periph_en_o),
    .periph_we_o    (periph_we_o),
    .bmask_o        (bmask_o),
    .wdata_o        (wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .periph_rdata_i (periph_rdata_i),
    .periph_ack_i   (periph_ack_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .busy_o         (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference load result: shift the addressed lane down, mask, extend by arithmetic.
  function automatic logic [31:0] exp_load(input logic [11:0] a, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    sh = 8 * int'(a[1:0]);
    v  = rd >> sh;
    case (sz)
      2'd0: begin
        v = v & 32'hFF;
        if (!uns && v >= 32'd128) v = v - 32'd256;
      end
      2'd1: begin
        v = v & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // One complete access, checked cycle by cycle. ack_cyc = strobe cycle carrying
  // the peripheral ack (0 = never acked).
  task automatic run_access(input logic [11:0] a, input logic we, input logic [1:0] sz,
                            input logic uns, input logic [31:0] wd, input logic [31:0] rd,
                            input int ack_cyc);
    logic        err, per, tmo;
    int          rsp_c, off, nb;
    logic [3:0]  bm;
    logic [31:0] wl, erd;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    per = a[11];
    tmo = 1'b0;
    if (err)                      rsp_c = 1;
    else if (per && ack_cyc == 0) begin rsp_c = TIMEOUT_CYC + 1; tmo = 1'b1; end
    else if (per)                 rsp_c = ack_cyc + 1;
    else                          rsp_c = MEM_LAT + 1;
    off = int'(a[1:0]);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < 4; i++) bm[i] = (i >= off) && (i < off + nb);
    wl  = (sz == 2'd0) ? (wd & 32'hFF) * 32'h01010101 :
          (sz == 2'd1) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    erd = (err || tmo || we) ? 32'h0 : exp_load(a, sz, uns, rd);

    @(negedge clk_i);
    check("idle_ready", 32'(req_ready_o), 32'd1);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_sel", 32'(addr_sel_o), 32'd3);
    req_valid_i    = 1'b1;
    req_addr_i     = a;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_wdata_i    = wd;
    periph_ack_i   = 1'($urandom);
    mem_rdata_i    = $urandom;
    periph_rdata_i = $urandom;

    for (int c = 1; c <= rsp_c; c++) begin
      @(negedge clk_i);
      if (c < rsp_c) begin
        check("busy_ready", 32'(req_ready_o), 32'd0);
        check("busy", 32'(busy_o), 32'd1);
        check("rsp_early", 32'(rsp_valid_o), 32'd0);
        check("mem_en", 32'(mem_en_o), 32'(!per));
        check("mem_we", 32'(mem_we_o), 32'(!per && we));
        check("periph_en", 32'(periph_en_o), 32'(per));
        check("periph_we", 32'(periph_we_o), 32'(per && we));
        check("addr_sel", 32'(addr_sel_o), per ? 32'd2 : 32'd0);
        check("addr_o", 32'(addr_o), 32'(a));
        check("bmask", 32'(bmask_o), 32'(bm));
        check("wdata", wdata_o, wl);
      end else begin
        check("rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("rsp_err", 32'(rsp_err_o), 32'(err || tmo));
        check("rsp_rdata", rsp_rdata_o, erd);
        check("rsp_mem_en", 32'(mem_en_o), 32'd0);
        check("rsp_periph_en", 32'(periph_en_o), 32'd0);
        check("rsp_sel", 32'(addr_sel_o), 32'd3);
        check("rsp_ready", 32'(req_ready_o), 32'd0);
      end
      // A second request held during the access must not be taken.
      if (c < rsp_c) begin
        req_valid_i = 1'b1;
        req_addr_i  = 12'($urandom);
        req_we_i    = 1'($urandom);
        req_size_i  = 2'($urandom);
        req_wdata_i = $urandom;
      end else begin
        req_valid_i = 1'b0;
      end
      mem_rdata_i    = (c == MEM_LAT) ? rd : $urandom;
      periph_rdata_i = (c == ack_cyc) ? rd : $urandom;
      periph_ack_i   = per ? (c == ack_cyc) : 1'($urandom);
    end
  endtask

  initial begin
    logic [11:0] ra;
    rst_i          = 1'b1;
    req_valid_i    = 1'b0;
    req_addr_i     = '0;
    req_we_i       = 1'b0;
    req_size_i     = '0;
    req_unsigned_i = 1'b0;
    req_wdata_i    = '0;
    mem_rdata_i    = '0;
    periph_rdata_i = '0;
    periph_ack_i   = 1'b0;

    repeat (2) @(negedge clk_i);
    check("rst_sel", 32'(addr_sel_o), 32'd3);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_strobes", 32'({mem_en_o, mem_we_o, periph_en_o, periph_we_o}), 32'd0);
    check("rst_rsp", 32'({rsp_valid_o, rsp_err_o}), 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    check("rst_bmask", 32'(bmask_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_addr", 32'(addr_o), 32'd0);
    rst_i = 1'b0;

    // Directed cases
    run_access(12'h010, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 0);
    run_access(12'h803, 1'b0, 2'd0, 1'b0, 32'h0, 32'h80000000, 3);
    run_access(12'h803, 1'b0, 2'd0, 1'b1, 32'h0, 32'h80000000, 3);
    run_access(12'h006, 1'b1, 2'd1, 1'b0, 32'h1234, 32'h55AA55AA, 0);
    run_access(12'h002, 1'b0, 2'd2, 1'b0, 32'h0, 32'h12345678, 0);
    run_access(12'h805, 1'b0, 2'd1, 1'b0, 32'h0, 32'h12345678, 2);
    run_access(12'h040, 1'b0, 2'd3, 1'b0, 32'h0, 32'h12345678, 0);
    run_access(12'hA42, 1'b1, 2'd1, 1'b0, 32'hCAFEBEEF, 32'h0, 1);
    run_access(12'h102, 1'b0, 2'd1, 1'b0, 32'h0, 32'h8001FFFF, 0);

    // Peripheral never acks
`ifdef LSU_CTRL_TIMEOUT_EN
    run_access(12'h900, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0BADF00D, 0);
    @(negedge clk_i);
    check("tmo_ready_after", 32'(req_ready_o), 32'd1);
`else
    @(negedge clk_i);
    check("stall_ready0", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = 12'h900;
    req_we_i    = 1'b0;
    req_size_i  = 2'd2;
    periph_ack_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (99) @(negedge clk_i);
    check("stall_busy100", 32'(busy_o), 32'd1);
    check("stall_periph_en100", 32'(periph_en_o), 32'd1);
    check("stall_ready100", 32'(req_ready_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("stall_recover", 32'(req_ready_o), 32'd1);
`endif

    // Reset during cycle 1 of a memory access
    @(negedge clk_i);
    check("mid_ready0", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = 12'h020;
    req_we_i    = 1'b0;
    req_size_i  = 2'd2;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("mid_mem_en1", 32'(mem_en_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("mid_async_mem_en", 32'(mem_en_o), 32'd0);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_sel", 32'(addr_sel_o), 32'd3);
    check("mid_mem_en", 32'(mem_en_o), 32'd0);
    check("mid_rsp", 32'(rsp_valid_o), 32'd0);
    check("mid_ready", 32'(req_ready_o), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("mid_no_rsp", 32'(rsp_valid_o), 32'd0);
    end

    // Randomized accesses
    for (int k = 0; k < 40; k++) begin
      ra = 12'($urandom);
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      run_access(ra, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                 int'($urandom_range(1, 5)));
    end

    @(negedge clk_i);
    check("final_idle", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
